// File: rtl/ntt_bf_addr_gen_pkg.sv
// Shared types and width helpers for the NTT butterfly address sequencer.
package ntt_bf_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of the stage field: must hold 0..LOGN (one past the final stage).
  function automatic int logn_w(input int logn);
    return $clog2(logn) + 32'sd1;
  endfunction

  // Width of the drain counter; at least one bit even when there is no drain.
  function automatic int cnt_w(input int n);
    return (n < 32'sd1) ? 32'sd1 : $clog2(n + 32'sd1);
  endfunction

endpackage

// File: rtl/ntt_bf_addr_gen_index.sv
// Combinational butterfly index map: (k, stage, inv) -> operand addresses, twiddle index, last flag.
module ntt_bf_index
  import ntt_bf_addr_gen_pkg::*;
#(
  parameter int LOGN = 8,
  localparam int LOGN_W = logn_w(LOGN)
) (
  input  logic [LOGN-2:0]   k,
  input  logic [LOGN_W-1:0] stage,
  input  logic              inv,
  output logic [LOGN-1:0]   addr_a,
  output logic [LOGN-1:0]   addr_b,
  output logic [LOGN-1:0]   tf_addr,
  output logic              last
);

  localparam logic [LOGN-1:0] ONE = {{(LOGN-1){1'b0}}, 1'b1};

  logic [LOGN_W-1:0] rev_s;
  logic [LOGN_W-1:0] len_sh_s;
  logic [LOGN_W-1:0] tf_sh_s;
  logic [LOGN-1:0]   k_s;
  logic [LOGN-1:0]   len_s;
  logic [LOGN-1:0]   g_s;
  logic [LOGN-1:0]   j_s;

  // Forward spans shrink with the stage while inverse spans grow, so the two exponents swap roles.
  always_comb begin
    rev_s    = LOGN_W'(LOGN - 1) - stage;
    len_sh_s = inv ? stage : rev_s;
    tf_sh_s  = inv ? rev_s : stage;
    k_s      = {1'b0, k};
    len_s    = ONE << len_sh_s;
    g_s      = k_s >> len_sh_s;
    j_s      = k_s & (len_s - ONE);
    addr_a   = ((g_s << len_sh_s) << 1'b1) | j_s;
    addr_b   = addr_a + len_s;
    tf_addr  = (ONE << tf_sh_s) + g_s;
    last     = &k;
  end

endmodule

// File: rtl/ntt_bf_addr_gen.sv
// NTT butterfly sequencer: walks all stages/butterflies with a valid/ready beat interface and
// a writeback drain between stages.
module ntt_bf_addr_gen
  import ntt_bf_addr_gen_pkg::*;
#(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 6,
  localparam int LOGN_W  = logn_w(LOGN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inv_in,
  input  logic              ready,
  output logic              valid,
  output logic [LOGN-1:0]   addr_a,
  output logic [LOGN-1:0]   addr_b,
  output logic [LOGN-1:0]   tf_addr,
  output logic              inv,
  output logic [LOGN_W-1:0] stage,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam int  CNT_W    = cnt_w(PIPE_LAT);
  localparam bit  NO_DRAIN = (PIPE_LAT == 32'sd0);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [LOGN-2:0]   k_r;
  logic [LOGN_W-1:0] stage_r;
  logic [LOGN-1:0]   addr_a_r;
  logic [LOGN-1:0]   addr_b_r;
  logic [LOGN-1:0]   tf_addr_r;
  logic              last_r;
  logic              valid_r;
  logic              inv_r;
  logic              busy_r;
  logic              done_r;

  logic [LOGN-2:0]   k_nxt_s;
  logic [LOGN_W-1:0] stage_nxt_s;
  logic              inv_nxt_s;
  logic              load_s;
  logic              final_s;
  logic              drain_end_s;
  logic [LOGN-1:0]   idx_a_s;
  logic [LOGN-1:0]   idx_b_s;
  logic [LOGN-1:0]   idx_tf_s;
  logic              idx_last_s;

  assign final_s     = (stage_r == LOGN_W'(LOGN - 1));
  assign drain_end_s = (cnt_r == CNT_W'(PIPE_LAT));

  // Upcoming beat: which (k, stage) the next issued butterfly carries and whether it issues now.
  always_comb begin
    k_nxt_s     = k_r + 1'b1;
    stage_nxt_s = stage_r;
    inv_nxt_s   = inv_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        k_nxt_s     = '0;
        stage_nxt_s = '0;
        inv_nxt_s   = inv_in;
        load_s      = start;
      end
      ST_ISSUE: begin
        if (last_r) begin
          k_nxt_s     = '0;
          stage_nxt_s = stage_r + 1'b1;
        end else begin
          k_nxt_s     = k_r + 1'b1;
        end
        load_s = valid_r && ready && (!last_r || (NO_DRAIN && !final_s));
      end
      ST_DRAIN: begin
        k_nxt_s     = '0;
        stage_nxt_s = stage_r + 1'b1;
        load_s      = drain_end_s && !final_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  ntt_bf_index #(
    .LOGN (LOGN)
  ) u_index (
    .k       (k_nxt_s),
    .stage   (stage_nxt_s),
    .inv     (inv_nxt_s),
    .addr_a  (idx_a_s),
    .addr_b  (idx_b_s),
    .tf_addr (idx_tf_s),
    .last    (idx_last_s)
  );

  // Beat registers: capture a new butterfly only when one issues, so a stalled beat stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r       <= '0;
      stage_r   <= '0;
      addr_a_r  <= '0;
      addr_b_r  <= '0;
      tf_addr_r <= '0;
      last_r    <= 1'b0;
    end else if (load_s) begin
      k_r       <= k_nxt_s;
      stage_r   <= stage_nxt_s;
      addr_a_r  <= idx_a_s;
      addr_b_r  <= idx_b_s;
      tf_addr_r <= idx_tf_s;
      last_r    <= idx_last_s;
    end
  end

  // Control FSM: stage sequencing, drain timing and the handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      valid_r <= 1'b0;
      inv_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_ISSUE;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            inv_r   <= inv_in;
          end
        end
        ST_ISSUE: begin
          if (valid_r && ready && last_r) begin
            if (NO_DRAIN) begin
              if (final_s) begin
                state_r <= ST_DONE;
                valid_r <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                valid_r <= 1'b1;
              end
            end else begin
              state_r <= ST_DRAIN;
              valid_r <= 1'b0;
              cnt_r   <= CNT_W'(1'b1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            if (final_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ISSUE;
              valid_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign valid   = valid_r;
  assign addr_a  = addr_a_r;
  assign addr_b  = addr_b_r;
  assign tf_addr = tf_addr_r;
  assign inv     = inv_r;
  assign stage   = stage_r;
  assign last    = last_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_ntt_bf_addr_gen.sv
// Self-checking bench for ntt_bf_addr_gen (LOGN=3, PIPE_LAT=4): formula-level beat model plus
// directed timing/literal checks.
module tb_ntt_bf_addr_gen;

  localparam int LOGN     = 3;
  localparam int PIPE_LAT = 4;
  localparam int HALF     = 4;
  localparam int LOGN_W   = 3;

  logic clk = 1'b0;
  logic rst, start, inv_in, ready;
  logic valid, inv, last, busy, done;
  logic [LOGN-1:0]   addr_a, addr_b, tf_addr;
  logic [LOGN_W-1:0] stage;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int acc_cnt   = 0;

  typedef struct {
    int a;
    int b;
    int tf;
    int st;
    int lst;
    int iv;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  ntt_bf_addr_gen #(
    .LOGN     (LOGN),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inv_in  (inv_in),
    .ready   (ready),
    .valid   (valid),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .tf_addr (tf_addr),
    .inv     (inv),
    .stage   (stage),
    .last    (last),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input int act, input int want);
    total_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beat order straight from the index-map formulas.
  task automatic load_model(input int iv);
    beat_t e;
    int len, tfb, g, j;
    for (int s = 0; s < LOGN; s++) begin
      len = (iv != 0) ? (2 ** s) : (2 ** (LOGN - 1 - s));
      tfb = (iv != 0) ? (2 ** (LOGN - 1 - s)) : (2 ** s);
      for (int k = 0; k < HALF; k++) begin
        g     = k / len;
        j     = k % len;
        e.a   = 2 * g * len + j;
        e.b   = e.a + len;
        e.tf  = tfb + g;
        e.st  = s;
        e.lst = (k == HALF - 1) ? 1 : 0;
        e.iv  = iv;
        exp_q.push_back(e);
      end
    end
  endtask

  // Per-cycle compare of every presented beat against the model queue.
  initial begin : compare
    bit    stall_prev;
    beat_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_valid_held", int'(valid), 1);
        if (valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", int'(valid), 0);
          end else begin
            e = exp_q[0];
            chk("model_addr_a", int'(addr_a), e.a);
            chk("model_addr_b", int'(addr_b), e.b);
            chk("model_tf_addr", int'(tf_addr), e.tf);
            chk("model_stage", int'(stage), e.st);
            chk("model_last", int'(last), e.lst);
            chk("model_inv", int'(inv), e.iv);
            if (ready) begin
              void'(exp_q.pop_front());
              acc_cnt++;
            end
          end
        end
        stall_prev = valid && !ready;
      end
    end
  end

  // Full run with ready=1, checking the cycle-exact frame and hand-computed beats.
  task automatic run_timed(input int iv, input int pulse_busy);
    int vexp;
    acc_cnt = 0;
    load_model(iv);
    inv_in = iv[0];
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int off = 1; off <= 26; off++) begin
      vexp = (off <= 24 && ((off - 1) % 8) < 4) ? 1 : 0;
      chk("valid_timing", int'(valid), vexp);
      chk("done_timing", int'(done), int'(off == 25));
      if (off != 25) chk("busy_timing", int'(busy), int'(off < 25));
      if (iv == 0) begin
        case (off)
          1:  begin chk("f_s0k0_a", int'(addr_a), 0); chk("f_s0k0_b", int'(addr_b), 4);
                    chk("f_s0k0_tf", int'(tf_addr), 1); end
          4:  begin chk("f_s0k3_a", int'(addr_a), 3); chk("f_s0k3_b", int'(addr_b), 7);
                    chk("f_s0k3_tf", int'(tf_addr), 1); chk("f_s0k3_last", int'(last), 1); end
          9:  begin chk("f_s1k0_stage", int'(stage), 1); chk("f_s1k0_a", int'(addr_a), 0);
                    chk("f_s1k0_b", int'(addr_b), 2); chk("f_s1k0_tf", int'(tf_addr), 2); end
          11: begin chk("f_s1k2_a", int'(addr_a), 4); chk("f_s1k2_b", int'(addr_b), 6);
                    chk("f_s1k2_tf", int'(tf_addr), 3); end
          20: begin chk("f_s2k3_stage", int'(stage), 2); chk("f_s2k3_a", int'(addr_a), 6);
                    chk("f_s2k3_b", int'(addr_b), 7); chk("f_s2k3_tf", int'(tf_addr), 7);
                    chk("f_s2k3_last", int'(last), 1); end
          default: begin end
        endcase
      end else begin
        case (off)
          2:  begin chk("i_s0k1_a", int'(addr_a), 2); chk("i_s0k1_b", int'(addr_b), 3);
                    chk("i_s0k1_tf", int'(tf_addr), 5); chk("i_inv", int'(inv), 1); end
          17: begin chk("i_s2k0_stage", int'(stage), 2); chk("i_s2k0_a", int'(addr_a), 0);
                    chk("i_s2k0_b", int'(addr_b), 4); chk("i_s2k0_tf", int'(tf_addr), 1); end
          default: begin end
        endcase
      end
      if (pulse_busy != 0) start = (off == 5 || off == 12);
      if (off < 26) step();
    end
    chk("beats_accepted", acc_cnt, 12);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk("done_within_bound", int'(done), 1);
  endtask

  initial begin
    int n;
    int dcount;
    rst = 1'b1; start = 1'b0; inv_in = 1'b0; ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", int'(valid), 0);
    chk("rst_addr_a", int'(addr_a), 0);
    chk("rst_addr_b", int'(addr_b), 0);
    chk("rst_tf_addr", int'(tf_addr), 0);
    chk("rst_inv", int'(inv), 0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    step();
    chk("idle_valid", int'(valid), 0);

    run_timed(0, 0);
    run_timed(1, 0);

    // Random backpressure: same 12 beats, same order, held while stalled.
    acc_cnt = 0;
    load_model(0);
    inv_in = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    ready = 1'b1;
    chk("rand_done", int'(done), 1);
    chk("rand_beats_accepted", acc_cnt, 12);
    chk("rand_model_drained", exp_q.size(), 0);
    step();

    // Start pulses while busy are ignored; a start right after done restarts cleanly.
    run_timed(0, 1);
    acc_cnt = 0;
    load_model(0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_valid", int'(valid), 1);
    chk("restart_addr_a", int'(addr_a), 0);
    chk("restart_addr_b", int'(addr_b), 4);
    chk("restart_stage", int'(stage), 0);
    wait_done(100, n);
    chk("restart_done_latency", n, 24);
    chk("restart_beats", acc_cnt, 12);
    step();

    // Reset in the middle of stage 1, k=1.
    acc_cnt = 0;
    load_model(0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("pre_rst_stage", int'(stage), 1);
    chk("pre_rst_addr_a", int'(addr_a), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_stage", int'(stage), 0);
    chk("mid_rst_done", int'(done), 0);
    dcount = 0;
    repeat (40) begin
      step();
      if (done) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);
    chk("idle_after_rst_busy", int'(busy), 0);

    // start and rst together: reset wins.
    start = 1'b1;
    rst   = 1'b1;
    step();
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_wins_valid", int'(valid), 0);
    chk("rst_wins_busy", int'(busy), 0);
    step();
    chk("rst_wins_still_idle", int'(valid), 0);

    acc_cnt = 0;
    load_model(0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_busy", int'(busy), 1);
    chk("post_rst_addr_a", int'(addr_a), 0);
    chk("post_rst_addr_b", int'(addr_b), 4);
    chk("post_rst_stage", int'(stage), 0);
    wait_done(100, n);
    chk("post_rst_done_latency", n, 24);
    chk("post_rst_beats", acc_cnt, 12);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
